// File: rtl/omok_pkg.sv
// Shared constants, cell encodings and FSM states for the Omok move sequencer.
package omok_pkg;

  localparam int MAP_N   = 10;
  localparam int WIN_LEN = 5;
  localparam int POS_W   = 8;
  localparam int CELLS   = MAP_N * MAP_N;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b10;
  localparam logic [1:0] WHITE = 2'b11;

  typedef enum logic [3:0] {
    IDLE, OCC_RD, OCC_CMP, PLACE, SCAN_ISSUE, SCAN_CMP, UNDO, OVER, CLEAR
  } state_t;

  // Scan directions: 0 horizontal, 1 vertical, 2 down-right, 3 down-left.
  localparam int DIR_DR [4] = '{0, 1, 1, 1};
  localparam int DIR_DC [4] = '{1, 0, 1, -1};

endpackage

// File: rtl/omok_line_walker.sv
// Combinational probe-address generator: cell at pos + side*step*(dr,dc).
// Row and column are checked separately, so a line never wraps across a row edge.
module omok_line_walker
  import omok_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic [1:0]       dir,
  input  logic             side,
  input  logic [2:0]       step,
  output logic             in_bounds,
  output logic [POS_W-1:0] addr
);

  int row, col, dr, dc, r, c;

  always_comb begin
    row       = int'(pos) / MAP_N;
    col       = int'(pos) % MAP_N;
    dr        = side ? -DIR_DR[dir] : DIR_DR[dir];
    dc        = side ? -DIR_DC[dir] : DIR_DC[dir];
    r         = row + dr * int'(step);
    c         = col + dc * int'(step);
    in_bounds = (r >= 0) && (r < MAP_N) && (c >= 0) && (c < MAP_N);
    addr      = in_bounds ? POS_W'(r * MAP_N + c) : '0;
  end

endmodule

// File: rtl/omok_game_ctrl.sv
// Omok move sequencer: places stones, scans the new stone's four lines for a win, one-level undo.
// Put write lands 3 cycles after the edge; button edges seen while busy are dropped.
module omok_game_ctrl
  import omok_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             put_req,
  input  logic             undo_req,
  input  logic [POS_W-1:0] cur_pos,
  output logic [POS_W-1:0] rd_addr,
  input  logic [1:0]       rd_data,
  output logic             wr_en,
  output logic [POS_W-1:0] wr_addr,
  output logic [1:0]       wr_data,
  output logic             clear,
  output logic             turn,
  output logic             busy,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic [6:0]       move_count
);

  state_t           state, state_nxt, end_state;
  logic             run, put_prev, undo_prev, put_edge, undo_edge;
  logic [POS_W-1:0] pos, last_pos, walk_addr;
  logic [1:0]       colour, dir;
  logic             side, last_valid, walk_ok, side_done, win, full;
  logic [3:0]       cnt;
  logic [2:0]       step;

  assign put_edge  = put_req & ~put_prev;
  assign undo_edge = undo_req & ~undo_prev;
  assign win       = cnt >= 4'(WIN_LEN);
  assign full      = move_count == 7'(CELLS);

  omok_line_walker u_walk (
    .pos(pos), .dir(dir), .side(side), .step(step),
    .in_bounds(walk_ok), .addr(walk_addr)
  );

  always_comb begin
    side_done = 1'b0;
    if (state == SCAN_ISSUE) side_done = !walk_ok || (step == 3'(WIN_LEN));
    else if (state == SCAN_CMP) side_done = rd_data != colour;

    end_state = SCAN_ISSUE;
    if (side) begin
      if (win) end_state = OVER;
      else if (dir == 2'd3) end_state = full ? OVER : IDLE;
    end

    state_nxt = state;
    case (state)
      CLEAR:      if (run) state_nxt = IDLE;
      IDLE: begin
        if (put_edge) begin
          if (cur_pos < POS_W'(CELLS)) state_nxt = OCC_RD;
        end else if (undo_edge && last_valid) begin
          state_nxt = UNDO;
        end
      end
      OCC_RD:     state_nxt = OCC_CMP;
      OCC_CMP:    state_nxt = (rd_data == EMPTY) ? PLACE : IDLE;
      PLACE:      state_nxt = SCAN_ISSUE;
      SCAN_ISSUE: state_nxt = side_done ? end_state : SCAN_CMP;
      SCAN_CMP:   state_nxt = side_done ? end_state : SCAN_ISSUE;
      UNDO:       state_nxt = IDLE;
      OVER:       if (put_edge) state_nxt = CLEAR;
      default:    state_nxt = CLEAR;
    endcase

    // run is low only in the cycle after reset, keeping every output at zero there.
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = EMPTY;
    clear     = (state == CLEAR) && run;
    busy      = !(state == IDLE || state == OVER) && run;
    game_over = state == OVER;
    case (state)
      OCC_RD:     rd_addr = pos;
      SCAN_ISSUE: rd_addr = walk_addr;
      PLACE: begin
        wr_en   = 1'b1;
        wr_addr = pos;
        wr_data = colour;
      end
      UNDO: begin
        wr_en   = 1'b1;
        wr_addr = last_pos;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAR;
      run        <= 1'b0;
      put_prev   <= 1'b0;
      undo_prev  <= 1'b0;
      pos        <= '0;
      last_pos   <= '0;
      last_valid <= 1'b0;
      colour     <= EMPTY;
      dir        <= '0;
      side       <= 1'b0;
      cnt        <= '0;
      step       <= '0;
      turn       <= 1'b0;
      winner     <= EMPTY;
      move_count <= '0;
    end else begin
      state     <= state_nxt;
      run       <= 1'b1;
      put_prev  <= put_req;
      undo_prev <= undo_req;
      case (state)
        CLEAR: begin
          turn       <= 1'b0;
          move_count <= '0;
          winner     <= EMPTY;
          last_valid <= 1'b0;
        end
        IDLE: if (put_edge && cur_pos < POS_W'(CELLS)) begin
          pos    <= cur_pos;
          colour <= turn ? WHITE : BLACK;
        end
        PLACE: begin
          move_count <= move_count + 7'd1;
          last_pos   <= pos;
          last_valid <= 1'b1;
          dir        <= '0;
          side       <= 1'b0;
          cnt        <= 4'd1;
          step       <= 3'd1;
        end
        SCAN_ISSUE, SCAN_CMP: begin
          if (side_done) begin
            step <= 3'd1;
            if (!side) begin
              side <= 1'b1;
            end else if (win) begin
              winner <= colour;
            end else if (dir == 2'd3) begin
              if (full) winner <= EMPTY;
              else      turn   <= ~turn;
            end else begin
              dir  <= dir + 2'd1;
              cnt  <= 4'd1;
              side <= 1'b0;
            end
          end else if (state == SCAN_CMP) begin
            cnt  <= cnt + 4'd1;
            step <= step + 3'd1;
          end
        end
        UNDO: begin
          turn       <= ~turn;
          move_count <= move_count - 7'd1;
          last_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_omok_game_ctrl.sv
// Bench for omok_game_ctrl: board-store model plus a game-rules reference, directed games then random play.
module tb_omok_game_ctrl;
  import omok_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, put_req = 1'b0, undo_req = 1'b0;
  logic [7:0] cur_pos = 8'd0, rd_addr, wr_addr;
  logic [1:0] rd_data, wr_data, winner;
  logic       wr_en, clear, turn, busy, game_over;
  logic [6:0] move_count;

  always #5 clk = ~clk;

  omok_game_ctrl dut (
    .clk(clk), .rst(rst), .put_req(put_req), .undo_req(undo_req), .cur_pos(cur_pos),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear), .turn(turn), .busy(busy), .game_over(game_over), .winner(winner),
    .move_count(move_count)
  );

  logic [1:0] mem [100];
  always @(posedge clk) begin
    rd_data <= (rd_addr < 8'd100) ? mem[rd_addr] : 2'b00;
    if (clear) for (int i = 0; i < 100; i++) mem[i] <= 2'b00;
    else if (wr_en && wr_addr < 8'd100) mem[wr_addr] <= wr_data;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference game state.
  int m_board [100];
  int m_turn, m_count, m_over, m_winner, m_last, m_lvalid;

  function automatic void model_clear();
    for (int i = 0; i < 100; i++) m_board[i] = 0;
    m_turn = 0; m_count = 0; m_over = 0; m_winner = 0; m_lvalid = 0; m_last = 0;
  endfunction

  function automatic int run_len(int p, int dr, int dc, int col);
    int r = p / 10, c = p % 10, n = 0;
    for (int k = 1; k < 5; k++) begin
      r += dr; c += dc;
      if (r < 0 || r > 9 || c < 0 || c > 9) break;
      if (m_board[r*10 + c] != col) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit makes_five(int p, int col);
    int drs [4] = '{0, 1, 1, 1};
    int dcs [4] = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++)
      if (1 + run_len(p, drs[d], dcs[d], col) + run_len(p, -drs[d], -dcs[d], col) >= 5) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_press(input bit is_put, input bit is_undo, input int p,
                             output bit e_wr, output int e_addr, output int e_data, output bit e_clr);
    int col;
    e_wr = 0; e_addr = 0; e_data = 0; e_clr = 0;
    if (is_put) begin
      if (m_over != 0) begin
        model_clear();
        e_clr = 1;
      end else if (p < 100 && m_board[p] == 0) begin
        col = (m_turn != 0) ? 3 : 2;
        m_board[p] = col;
        e_wr = 1; e_addr = p; e_data = col;
        m_count++; m_last = p; m_lvalid = 1;
        if (makes_five(p, col)) begin m_over = 1; m_winner = col; end
        else if (m_count == 100) begin m_over = 1; m_winner = 0; end
        else m_turn ^= 1;
      end
    end else if (is_undo && m_over == 0 && m_lvalid != 0) begin
      e_wr = 1; e_addr = m_last; e_data = 0;
      m_board[m_last] = 0; m_turn ^= 1; m_count--; m_lvalid = 0;
    end
  endtask

  task automatic press(input bit is_put, input bit is_undo, input int p, input string tag, output int bc);
    bit e_wr, e_clr, done;
    int e_addr, e_data, wr_cyc, nwr, nclr;
    logic [7:0] wa;
    logic [1:0] wd;
    model_press(is_put, is_undo, p, e_wr, e_addr, e_data, e_clr);
    @(negedge clk);
    cur_pos = p[7:0]; put_req = is_put; undo_req = is_undo;
    wr_cyc = 0; nwr = 0; nclr = 0; bc = 0; done = 0; wa = 0; wd = 0;
    for (int n = 1; n <= 100 && !done; n++) begin
      @(negedge clk);
      if (wr_en) begin
        if (nwr == 0) begin wr_cyc = n; wa = wr_addr; wd = wr_data; end
        nwr++;
      end
      if (clear) nclr++;
      if (busy) bc++;
      else done = 1;
    end
    put_req = 0; undo_req = 0;
    chk({tag, ":idle_reached"}, done, 1);
    chk({tag, ":writes"}, nwr, e_wr);
    if (e_wr) begin
      chk({tag, ":wr_addr"}, wa, e_addr);
      chk({tag, ":wr_data"}, wd, e_data);
      chk({tag, ":wr_cycle"}, wr_cyc, is_put ? 3 : 1);
    end
    chk({tag, ":clear_pulses"}, nclr, e_clr);
    chk({tag, ":busy_bound"}, bc <= 75, 1);
    chk({tag, ":turn"}, turn, m_turn);
    chk({tag, ":move_count"}, move_count, m_count);
    chk({tag, ":game_over"}, game_over, m_over);
    chk({tag, ":winner"}, winner, m_winner);
  endtask

  task automatic do_reset(input string tag);
    int nclr = 0;
    rst = 0;
    #1;
    chk({tag, ":outs_zero"}, {rd_addr, wr_en, wr_addr, wr_data, clear, turn, busy, game_over,
                              winner, move_count}, 32'd0);
    put_req = 0; undo_req = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (6) begin
      @(negedge clk);
      if (clear) nclr++;
    end
    chk({tag, ":clear_pulses"}, nclr, 1);
    chk({tag, ":busy_after"}, busy, 0);
    chk({tag, ":count_after"}, move_count, 0);
    model_clear();
  endtask

  task automatic board_cmp(input string tag);
    int diff = 0;
    for (int i = 0; i < 100; i++) if (int'(mem[i]) != m_board[i]) diff++;
    chk({tag, ":board_diff"}, diff, 0);
  endtask

  initial begin
    int bc, seq [$], blk [$], wht [$], r, p;

    model_clear();
    #3;
    do_reset("por");

    // Black row 40..44 after the first stone at 44, white row 50..53 interleaved.
    press(1, 0, 44, "p44", bc);
    press(1, 0, 44, "occ44", bc);
    chk("occ44:busy_cycles", bc, 2);
    seq = '{50, 40, 51, 41, 52, 42, 53, 43};
    foreach (seq[i]) press(1, 0, seq[i], $sformatf("row_%0d", seq[i]), bc);
    chk("row_win:busy_fall", bc <= 75, 1);
    press(0, 1, 0, "undo_in_over", bc);
    press(1, 0, 0, "over_put", bc);

    // Stones 7..11 cross a row boundary and must not count as five.
    seq = '{7, 60, 8, 62, 9, 64, 10, 66, 11};
    foreach (seq[i]) press(1, 0, seq[i], $sformatf("wrap_%0d", seq[i]), bc);

    press(1, 0, 23, "p23", bc);
    press(0, 1, 0, "undo1", bc);
    press(0, 1, 0, "undo2", bc);
    press(1, 1, 24, "put_undo", bc);
    press(1, 0, 120, "out_of_range", bc);

    // Reset while the scan of a fresh stone is running.
    @(negedge clk);
    cur_pos = 8'd55; put_req = 1;
    repeat (5) @(negedge clk);
    chk("mid:busy_before", busy, 1);
    #2;
    do_reset("mid");

    // White down-left diagonal 9,18,27,36,45.
    seq = '{70, 9, 72, 18, 74, 27, 76, 36, 78, 45};
    foreach (seq[i]) press(1, 0, seq[i], $sformatf("diag_%0d", seq[i]), bc);
    board_cmp("diag");
    press(1, 0, 0, "over_put2", bc);

    // Full board whose colour pattern has runs of at most two in every direction.
    for (int i = 0; i < 100; i++) begin
      if ((((i % 10) / 2) + (i / 10)) % 2 == 0) blk.push_back(i);
      else wht.push_back(i);
    end
    for (int i = 0; i < 50; i++) begin
      press(1, 0, blk[i], "fill_b", bc);
      press(1, 0, wht[i], "fill_w", bc);
    end
    chk("draw:game_over", game_over, 1);
    chk("draw:winner", winner, 0);
    board_cmp("draw");
    press(1, 0, 0, "over_put3", bc);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      p = ($urandom_range(0, 99) < 5) ? 100 + $urandom_range(0, 5) : $urandom_range(30, 69);
      if (r < 12)      press(0, 1, p, "rnd_undo", bc);
      else if (r < 17) press(1, 1, p, "rnd_both", bc);
      else             press(1, 0, p, "rnd_put", bc);
    end
    board_cmp("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
